alu_issue_ctrl: RTL and testbench

Sequential issue/capture stage wrapped around the team's 8-bit combinational ALU core.
- Upstream: accepts commands (opcode plus operands) over a valid/ready handshake.
- Datapath: registers the operands, drives the ALU core, and captures result and flags.
- Downstream: presents the captured result over a valid/ready handshake.
- State: keeps an accumulator (optional A-operand source), sticky flags, and a completed-operation counter for the datapath controller.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_operations.sv | 49 ++++
 rtl/alu_issue_ctrl.sv | 122 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/capture stage: opcodes, flag bit positions
// and the issue FSM state encoding.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_INC = 3'd2;
    localparam logic [2:0] OP_DEC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_NOT = 3'd7;

    localparam int FLG_C = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_V = 1;
    localparam int FLG_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/alu_operations.sv
// Combinational 8-bit ALU core. Carry and overflow are produced by ADD only;
// every other opcode reports them as 0.
module alu_operations
    import alu_pkg::*;
(
    input  logic [2:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] result,
    output logic [3:0] flags
);

    // Two's-complement overflow: equal operand signs, result sign differs.
    function automatic logic add_ovf(input logic signed [7:0] x,
                                     input logic signed [7:0] y,
                                     input logic signed [7:0] s);
        return (x[7] == y[7]) && (s[7] != x[7]);
    endfunction

    logic [8:0] sum9;
    logic       carry;
    logic       ovf;

    always_comb begin
        sum9   = {1'b0, a} + {1'b0, b};
        carry  = 1'b0;
        ovf    = 1'b0;
        result = '0;
        case (op)
            OP_ADD: begin
                {carry, result} = sum9;
                ovf = add_ovf(a, b, sum9[7:0]);
            end
            OP_SUB:  result = a - b;
            OP_INC:  result = a + 8'd1;
            OP_DEC:  result = a - 8'd1;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: result = ~a;
        endcase
        flags        = '0;
        flags[FLG_C] = carry;
        flags[FLG_Z] = (result == 8'd0);
        flags[FLG_V] = ovf;
        flags[FLG_N] = result[7];
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/capture stage around alu_operations: valid/ready command intake, one-cycle
// execute, held result with flags, accumulator, sticky flags and op counter.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int         CNT_W    = 16,
    parameter logic [7:0] ACC_INIT = 8'h00
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_opcode,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic             cmd_use_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_result,
    output logic [3:0]       out_flags,
    output logic [1:0]       sticky_flags,
    input  logic             flags_clr,
    output logic [CNT_W-1:0] op_count
);

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [7:0]       a_q, a_d;
    logic [7:0]       b_q, b_d;
    logic [7:0]       res_q, res_d;
    logic [3:0]       flg_q, flg_d;
    logic [7:0]       acc_q, acc_d;
    logic [1:0]       sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       alu_res;
    logic [3:0]       alu_flg;
    logic             accept;
    logic             deliver;

    alu_operations u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_res),
        .flags  (alu_flg)
    );

    // In HOLD a new command may enter only on the cycle the held result leaves.
    assign cmd_ready = rst_n && ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready));
    assign out_valid = (state_q == ST_HOLD);
    assign accept    = cmd_valid && cmd_ready;
    assign deliver   = out_valid && out_ready;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        flg_d    = flg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sticky_d = flags_clr ? 2'b00 : sticky_q;

        if (accept) begin
            op_d = cmd_opcode;
            a_d  = cmd_use_acc ? acc_q : cmd_a;
            b_d  = cmd_b;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                res_d    = alu_res;
                flg_d    = alu_flg;
                acc_d    = alu_res;
                // A coincident clear drops history but keeps this capture's events.
                sticky_d = sticky_d | {alu_flg[FLG_C], alu_flg[FLG_V]};
                state_d  = ST_HOLD;
            end
            ST_HOLD: begin
                if (deliver) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = accept ? ST_EXEC : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            flg_q    <= '0;
            acc_q    <= ACC_INIT;
            sticky_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            flg_q    <= flg_d;
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_result   = res_q;
    assign out_flags    = flg_q;
    assign sticky_flags = sticky_q;
    assign op_count     = cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed cases plus randomized traffic checked
// against an arithmetic reference model, with a separate output monitor.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_opcode;
    logic [7:0]       cmd_a;
    logic [7:0]       cmd_b;
    logic             cmd_use_acc;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_result;
    logic [3:0]       out_flags;
    logic [1:0]       sticky_flags;
    logic             flags_clr;
    logic [CNT_W-1:0] op_count;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.CNT_W(CNT_W), .ACC_INIT(8'h00)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_opcode   (cmd_opcode),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_use_acc  (cmd_use_acc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .sticky_flags (sticky_flags),
        .flags_clr    (flags_clr),
        .op_count     (op_count)
    );

    typedef struct {
        logic [7:0] res;
        logic [3:0] flg;
        logic [1:0] sticky;
    } exp_t;

    exp_t       sb_q[$];
    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] m_acc = 8'h00;
    logic [1:0] m_sticky = 2'b00;
    int         m_cnt = 0;
    int         ready_mode = 2;   // 0 random, 1 stall, 2 always ready

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Reference model: plain integer arithmetic on the opcode definitions.
    function automatic void ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] r, output logic [3:0] f);
        int ai, bi, s, sa, sb_s, ss;
        logic c, v;
        ai = int'(a);
        bi = int'(b);
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: begin
                s    = ai + bi;
                c    = (s > 255);
                sa   = (ai > 127) ? ai - 256 : ai;
                sb_s = (bi > 127) ? bi - 256 : bi;
                ss   = sa + sb_s;
                v    = (ss > 127) || (ss < -128);
            end
            3'd1:    s = ai - bi;
            3'd2:    s = ai + 1;
            3'd3:    s = ai - 1;
            3'd4:    s = ai & bi;
            3'd5:    s = ai | bi;
            3'd6:    s = ai ^ bi;
            default: s = 255 - ai;
        endcase
        r = s[7:0];
        f = {c, (r == 8'h00), v, r[7]};
    endfunction

    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1 && out_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    e = sb_q[0];
                    if (out_ready) begin
                        void'(sb_q.pop_front());
                        chk("result", out_result, e.res);
                        chk("flags", out_flags, e.flg);
                        chk("sticky", sticky_flags, e.sticky);
                        chk("op_count", op_count, m_cnt % 16);
                        m_cnt++;
                    end else begin
                        chk("hold_result", out_result, e.res);
                        chk("hold_flags", out_flags, e.flg);
                        chk("hold_cmd_ready", cmd_ready, 0);
                    end
                end
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic ua, input logic clr, output int waits);
        exp_t e;
        logic [7:0] aa;
        logic ok;
        waits = 0;
        ok = 1'b0;
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_opcode  = op;
        cmd_a       = a;
        cmd_b       = b;
        cmd_use_acc = ua;
        while (!ok && waits < 200) begin
            #1;
            ok = cmd_ready;
            @(posedge clk);
            if (!ok) begin
                waits++;
                @(negedge clk);
            end
        end
        if (!ok) begin
            chk("send_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        aa = ua ? m_acc : a;
        ref_alu(op, aa, b, e.res, e.flg);
        m_acc    = e.res;
        m_sticky = (clr ? 2'b00 : m_sticky) | {e.flg[3], e.flg[1]};
        e.sticky = m_sticky;
        sb_q.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
        flags_clr = clr;
        #1 chk("lat_exec_no_valid", out_valid, 0);
        @(posedge clk);
        #1;
        flags_clr = 1'b0;
        chk("lat_hold_valid", out_valid, 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((sb_q.size() != 0 || out_valid) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic clear_idle();
        @(negedge clk);
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        m_sticky  = 2'b00;
        #1 chk("sticky_cleared", sticky_flags, 0);
    endtask

    initial begin
        int w;
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_opcode  = 3'd0;
        cmd_a       = 8'h00;
        cmd_b       = 8'h00;
        cmd_use_acc = 1'b0;
        flags_clr   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_flags", out_flags, 0);
        chk("rst_sticky", sticky_flags, 0);
        chk("rst_op_count", op_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("idle_cmd_ready", cmd_ready, 1);

        // Overflow ADD, then carry ADD, then idle clear.
        send(OP_ADD, 8'h7F, 8'h01, 1'b0, 1'b0, w);
        wait_idle();
        chk("sticky_after_ovf", sticky_flags, 2'b01);
        chk("count_after_first", op_count, 1);
        send(OP_ADD, 8'hFF, 8'h01, 1'b0, 1'b0, w);
        wait_idle();
        chk("sticky_after_carry", sticky_flags, 2'b11);
        clear_idle();

        // Accumulator chain from 8'h00.
        for (int i = 0; i < 3; i++) send(OP_INC, 8'h55, 8'h00, 1'b1, 1'b0, w);
        wait_idle();

        // Backpressure, then same-cycle release and accept.
        ready_mode = 1;
        send(OP_XOR, 8'hA5, 8'h0F, 1'b0, 1'b0, w);
        repeat (5) @(negedge clk);
        #1;
        chk("bp_result", out_result, 8'hAA);
        chk("bp_cmd_ready", cmd_ready, 0);
        ready_mode = 2;
        send(OP_NOT, 8'h00, 8'h00, 1'b0, 1'b0, w);
        chk("same_cycle_accept", w, 0);
        wait_idle();

        // Clear coinciding with capture: new events kept, old history dropped.
        send(OP_ADD, 8'hFF, 8'h01, 1'b0, 1'b0, w);
        send(OP_ADD, 8'h7F, 8'h01, 1'b0, 1'b1, w);
        wait_idle();
        chk("clr_set_drop_old", sticky_flags, 2'b01);
        send(OP_ADD, 8'h80, 8'h80, 1'b0, 1'b1, w);
        wait_idle();
        chk("clr_set_both", sticky_flags, 2'b11);

        // Reset during EXEC discards the pending result.
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_opcode  = OP_SUB;
        cmd_a       = 8'h05;
        cmd_b       = 8'h03;
        cmd_use_acc = 1'b0;
        #1 chk("pre_rst_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_cmd_ready", cmd_ready, 0);
        chk("midrst_op_count", op_count, 0);
        chk("midrst_sticky", sticky_flags, 0);
        sb_q.delete();
        m_acc    = 8'h00;
        m_sticky = 2'b00;
        m_cnt    = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("post_rst_no_valid", out_valid, 0);
        end
        send(OP_DEC, 8'h77, 8'h00, 1'b1, 1'b0, w);
        wait_idle();

        // Randomized traffic with random backpressure and capture-time clears.
        ready_mode = 0;
        for (int i = 0; i < 40; i++) begin
            send(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), w);
        end
        wait_idle();
        ready_mode = 2;
        @(negedge clk);
        #1 chk("op_count_wrap", op_count, m_cnt % 16);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
